// File: rtl/cache_data_array_mp.sv
// Purpose : L1 D-cache data array (set-assoc, byte-masked writes); core pipeline and snoop path share one read port.
// Latency : read data returns READ_LAT (1 or 2) cycles after the accept edge; writes land on the clock edge.
// Backpres: snoop reads always accepted; core_rd_ready drops while a snoop is presented. Option macro: CACHE_DATA_PARITY_EN.
module cache_data_array_mp #(
   parameter  int SETS       = 128,
   parameter  int WAYS       = 4,
   parameter  int LINE_BYTES = 64,
   parameter  int DATA_WIDTH = LINE_BYTES * 8,
   parameter  int READ_LAT   = 1,
   localparam int SET_W      = $clog2(SETS),
   localparam int WAY_W      = $clog2(WAYS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  core_rd_valid,
   output logic                  core_rd_ready,
   input  logic [SET_W-1:0]      core_rd_set,
   input  logic [WAY_W-1:0]      core_rd_way,
   output logic                  core_rsp_valid,
   output logic [DATA_WIDTH-1:0] core_rsp_data,
   input  logic                  snp_rd_valid,
   input  logic [SET_W-1:0]      snp_rd_set,
   input  logic [WAY_W-1:0]      snp_rd_way,
   output logic                  snp_rsp_valid,
   output logic [DATA_WIDTH-1:0] snp_rsp_data,
   input  logic [SET_W-1:0]      wr_set,
   input  logic [WAY_W-1:0]      wr_way,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [LINE_BYTES-1:0] wr_mask,
   output logic                  par_err
);

   localparam int IDX_W   = SET_W + WAY_W;
   localparam int ENTRIES = SETS * WAYS;

   if (READ_LAT != 1 && READ_LAT != 2) begin : g_lat_chk
      $error("cache_data_array_mp: READ_LAT must be 1 or 2");
   end

   logic [DATA_WIDTH-1:0] r_mem [ENTRIES];

   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_rd_idx;
   logic                  w_acc;
   logic                  w_acc_snp;
   logic                  w_wr_hit;
   logic [DATA_WIDTH-1:0] w_rd_line;
   logic                  w_fin_vld;
   logic                  w_fin_snp;
   logic [DATA_WIDTH-1:0] w_fin_data;
   logic                  w_par_bad;

   logic                  r_core_vld;
   logic                  r_snp_vld;
   logic                  r_par_err;
   logic [DATA_WIDTH-1:0] r_core_dat;
   logic [DATA_WIDTH-1:0] r_snp_dat;

   // Snoop owns the read port whenever it asks; core only gets leftover cycles.
   assign core_rd_ready = ~snp_rd_valid;
   assign w_acc_snp     = snp_rd_valid;
   assign w_acc         = snp_rd_valid | (core_rd_valid & core_rd_ready);
   assign w_wr_idx      = {wr_set, wr_way};
   assign w_rd_idx      = snp_rd_valid ? {snp_rd_set, snp_rd_way} : {core_rd_set, core_rd_way};
   assign w_wr_hit      = (|wr_mask) && (w_wr_idx == w_rd_idx);

   // Byte-masked line write; unmasked bytes keep their contents.
   always_ff @(posedge clk) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (wr_mask[b]) r_mem[w_wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
   end

   // Read with same-cycle write bypass so a colliding read sees post-write bytes.
   always_comb begin
      w_rd_line = r_mem[w_rd_idx];
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (w_wr_hit && wr_mask[b]) w_rd_line[b*8 +: 8] = wr_data[b*8 +: 8];
      end
   end

   if (READ_LAT == 2) begin : g_s1
      logic                  r_s1_vld;
      logic                  r_s1_snp;
      logic [DATA_WIDTH-1:0] r_s1_data;

      // Stage-1 valid/owner; reset drops anything in flight.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_snp <= 1'b0;
         end else begin
            r_s1_vld <= w_acc;
            r_s1_snp <= w_acc_snp;
         end
      end

      // Stage-1 data capture, free-running (never stalled).
      always_ff @(posedge clk) begin
         r_s1_data <= w_rd_line;
      end

      assign w_fin_vld  = r_s1_vld;
      assign w_fin_snp  = r_s1_snp;
      assign w_fin_data = r_s1_data;
   end else begin : g_s0
      assign w_fin_vld  = w_acc;
      assign w_fin_snp  = w_acc_snp;
      assign w_fin_data = w_rd_line;
   end

`ifdef CACHE_DATA_PARITY_EN
   logic [LINE_BYTES-1:0] r_par [ENTRIES];
   logic [LINE_BYTES-1:0] w_rd_par;
   logic [LINE_BYTES-1:0] w_fin_par;

   // Even parity per byte, written only for masked bytes.
   always_ff @(posedge clk) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (wr_mask[b]) r_par[w_wr_idx][b] <= ^wr_data[b*8 +: 8];
      end
   end

   // Parity read with the same write bypass as the data.
   always_comb begin
      w_rd_par = r_par[w_rd_idx];
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (w_wr_hit && wr_mask[b]) w_rd_par[b] = ^wr_data[b*8 +: 8];
      end
   end

   if (READ_LAT == 2) begin : g_par_s1
      logic [LINE_BYTES-1:0] r_s1_par;
      // Parity travels alongside stage-1 data.
      always_ff @(posedge clk) begin
         r_s1_par <= w_rd_par;
      end
      assign w_fin_par = r_s1_par;
   end else begin : g_par_s0
      assign w_fin_par = w_rd_par;
   end

   // Any byte whose recomputed parity disagrees with the stored bit flags the response.
   always_comb begin
      w_par_bad = 1'b0;
      for (int b = 0; b < LINE_BYTES; b++) begin
         if ((^w_fin_data[b*8 +: 8]) != w_fin_par[b]) w_par_bad = 1'b1;
      end
   end
`else
   assign w_par_bad = 1'b0;
`endif

   // Output stage: only the owning client's valid pulses and data updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_core_vld <= 1'b0;
         r_snp_vld  <= 1'b0;
         r_par_err  <= 1'b0;
         r_core_dat <= '0;
         r_snp_dat  <= '0;
      end else begin
         r_core_vld <= w_fin_vld & ~w_fin_snp;
         r_snp_vld  <= w_fin_vld &  w_fin_snp;
         r_par_err  <= w_fin_vld &  w_par_bad;
         if (w_fin_vld && !w_fin_snp) r_core_dat <= w_fin_data;
         if (w_fin_vld &&  w_fin_snp) r_snp_dat  <= w_fin_data;
      end
   end

   assign core_rsp_valid = r_core_vld;
   assign core_rsp_data  = r_core_dat;
   assign snp_rsp_valid  = r_snp_vld;
   assign snp_rsp_data   = r_snp_dat;
   assign par_err        = r_par_err;

endmodule

// File: tb/tb_cache_data_array_mp.sv
// Bench for cache_data_array_mp: one READ_LAT=1 and one READ_LAT=2 instance driven by the same stimulus.
// Expected responses are queued per channel at issue time with their due cycle; a negedge monitor pops and compares.
// Channels: 0 = lat1 core, 1 = lat1 snoop, 2 = lat2 core, 3 = lat2 snoop.
module tb_cache_data_array_mp;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         core_rd_valid;
   logic [6:0]   core_rd_set;
   logic [1:0]   core_rd_way;
   logic         snp_rd_valid;
   logic [6:0]   snp_rd_set;
   logic [1:0]   snp_rd_way;
   logic [6:0]   wr_set;
   logic [1:0]   wr_way;
   logic [511:0] wr_data;
   logic [63:0]  wr_mask;

   logic         rdy1, rdy2, c1v, s1v, c2v, s2v, p1, p2;
   logic [511:0] c1d, s1d, c2d, s2d;

   typedef struct {
      int           due;
      logic [511:0] d;
      logic         p;
   } exp_t;

   exp_t         q [4][$];
   logic [511:0] last [4];
   logic [511:0] mdl [512];
   logic         vld [4];
   logic [511:0] dat [4];
   logic         par [4];
   int           total = 0;
   int           bad   = 0;
   int           ncnt  = 0;
   logic         exp_par = 1'b0;

   always #5 clk = ~clk;

   cache_data_array_mp #(.READ_LAT(1)) dut_l1 (
      .clk(clk), .rst_n(rst_n),
      .core_rd_valid(core_rd_valid), .core_rd_ready(rdy1),
      .core_rd_set(core_rd_set), .core_rd_way(core_rd_way),
      .core_rsp_valid(c1v), .core_rsp_data(c1d),
      .snp_rd_valid(snp_rd_valid), .snp_rd_set(snp_rd_set), .snp_rd_way(snp_rd_way),
      .snp_rsp_valid(s1v), .snp_rsp_data(s1d),
      .wr_set(wr_set), .wr_way(wr_way), .wr_data(wr_data), .wr_mask(wr_mask),
      .par_err(p1)
   );

   cache_data_array_mp #(.READ_LAT(2)) dut_l2 (
      .clk(clk), .rst_n(rst_n),
      .core_rd_valid(core_rd_valid), .core_rd_ready(rdy2),
      .core_rd_set(core_rd_set), .core_rd_way(core_rd_way),
      .core_rsp_valid(c2v), .core_rsp_data(c2d),
      .snp_rd_valid(snp_rd_valid), .snp_rd_set(snp_rd_set), .snp_rd_way(snp_rd_way),
      .snp_rsp_valid(s2v), .snp_rsp_data(s2d),
      .wr_set(wr_set), .wr_way(wr_way), .wr_data(wr_data), .wr_mask(wr_mask),
      .par_err(p2)
   );

   assign vld[0] = c1v;  assign dat[0] = c1d;  assign par[0] = p1;
   assign vld[1] = s1v;  assign dat[1] = s1d;  assign par[1] = p1;
   assign vld[2] = c2v;  assign dat[2] = c2d;  assign par[2] = p2;
   assign vld[3] = s2v;  assign dat[3] = s2d;  assign par[3] = p2;

   function automatic logic [511:0] pat(input int s);
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = (s * 32'h0100_0193) ^ (i * 32'h1111_1111) ^ 32'hA500_0000;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, a, e);
      end
   endtask

   task automatic push(input int snp, input logic [511:0] d);
      exp_t e;
      e.d = d;
      e.p = exp_par;
      e.due = ncnt + 1;  q[snp].push_back(e);
      e.due = ncnt + 2;  q[2 + snp].push_back(e);
   endtask

   task automatic idle();
      core_rd_valid = 1'b0; snp_rd_valid = 1'b0; wr_mask = '0;
      core_rd_set = '0; core_rd_way = '0; snp_rd_set = '0; snp_rd_way = '0;
      wr_set = '0; wr_way = '0; wr_data = '0;
   endtask

   // Drop expectations that reset discards and restart the data-hold tracking at 0.
   task automatic flush();
      for (int ch = 0; ch < 4; ch++) begin
         while (q[ch].size() > 0 && q[ch][$].due > ncnt) void'(q[ch].pop_back());
         last[ch] = '0;
      end
   endtask

   // One cycle of stimulus: optional core read, snoop read, masked write (line index = set*4+way).
   task automatic step(input bit cv, input int cidx, input bit sv, input int sidx,
                       input int widx, input logic [63:0] wm, input logic [511:0] wd);
      @(negedge clk); #1;
      core_rd_valid = cv; core_rd_set = 7'(cidx >> 2); core_rd_way = 2'(cidx);
      snp_rd_valid  = sv; snp_rd_set  = 7'(sidx >> 2); snp_rd_way  = 2'(sidx);
      wr_set = 7'(widx >> 2); wr_way = 2'(widx); wr_mask = wm; wr_data = wd;
      #1;
      chk("core_rd_ready_l1", {511'd0, rdy1}, {511'd0, ~sv});
      chk("core_rd_ready_l2", {511'd0, rdy2}, {511'd0, ~sv});
      for (int b = 0; b < 64; b++) if (wm[b]) mdl[widx][b*8 +: 8] = wd[b*8 +: 8];
      if (sv)            push(1, mdl[sidx]);
      else if (cv)       push(0, mdl[cidx]);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_c1v"}, {511'd0, c1v}, '0);
      chk({tag, "_s1v"}, {511'd0, s1v}, '0);
      chk({tag, "_c2v"}, {511'd0, c2v}, '0);
      chk({tag, "_s2v"}, {511'd0, s2v}, '0);
      chk({tag, "_c1d"}, c1d, '0);
      chk({tag, "_s1d"}, s1d, '0);
      chk({tag, "_c2d"}, c2d, '0);
      chk({tag, "_s2d"}, s2d, '0);
      chk({tag, "_p1"},  {511'd0, p1}, '0);
      chk({tag, "_p2"},  {511'd0, p2}, '0);
   endtask

   // Monitor: pop and compare on every response; flag late, spurious and non-held data.
   always @(negedge clk) begin
      exp_t e;
      ncnt++;
      for (int ch = 0; ch < 4; ch++) begin
         while (q[ch].size() > 0 && q[ch][0].due < ncnt) begin
            total++; bad++;
            $display("FAIL missed_rsp ch=%0d act=none exp_due=%0d now=%0d", ch, q[ch][0].due, ncnt);
            void'(q[ch].pop_front());
         end
         if (vld[ch] === 1'b1) begin
            if (q[ch].size() == 0) begin
               total++; bad++;
               $display("FAIL spurious_rsp ch=%0d act=valid exp=idle now=%0d", ch, ncnt);
            end else begin
               e = q[ch].pop_front();
               total++;
               if (e.due != ncnt || dat[ch] !== e.d || par[ch] !== e.p) begin
                  bad++;
                  $display("FAIL rsp ch=%0d now=%0d due=%0d par act=%b exp=%b data act=%0h exp=%0h",
                           ch, ncnt, e.due, par[ch], e.p, dat[ch], e.d);
               end
            end
            last[ch] = dat[ch];
         end else if (vld[ch ^ 1] === 1'b1) begin
            total++;
            if (dat[ch] !== last[ch]) begin
               bad++;
               $display("FAIL hold ch=%0d act=%0h exp=%0h", ch, dat[ch], last[ch]);
            end
         end
      end
   end

   initial begin
      #200000;
      total++; bad++;
      $display("FAIL watchdog act=running exp=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int ch = 0; ch < 4; ch++) last[ch] = '0;
      rst_n = 1'b0;
      idle();
      @(negedge clk); @(negedge clk); #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // T1: full-line write, then core read
      step(0, 0, 0, 0, 22, '1, pat(1));
      step(1, 22, 0, 0, 0, '0, '0);
      // T2: same-cycle byte0 write and read -> merged
      step(1, 22, 0, 0, 22, 64'h1, 512'hFF);
      // T3: core and snoop collide; snoop wins, core retries next cycle
      step(0, 0, 0, 0, 4, '1, pat(2));
      step(0, 0, 0, 0, 8, '1, pat(3));
      step(1, 4, 1, 8, 0, '0, '0);
      step(1, 4, 0, 0, 0, '0, '0);
      // snoop read merged with same-cycle partial write; other bytes retained
      step(0, 0, 1, 22, 22, 64'hF0, pat(4));
      // write to a neighbouring way during a core read: no merge into the read
      step(1, 4, 0, 0, 5, '1, pat(5));
      step(0, 0, 1, 5, 0, '0, '0);
      // T4: 8 distinct lines, then back-to-back core reads
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 40 + i, '1, pat(10 + i));
      for (int i = 0; i < 8; i++) step(1, 40 + i, 0, 0, 0, '0, '0);
      // a write after the accept cycle must not reach the in-flight read
      step(1, 40, 0, 0, 0, '0, '0);
      step(0, 0, 0, 0, 40, '1, pat(30));
      step(1, 40, 0, 0, 0, '0, '0);

      // T5: reset while reads are in flight
      step(1, 41, 0, 0, 0, '0, '0);
      step(0, 0, 1, 42, 0, '0, '0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle();
      flush();
      @(negedge clk); #1;
      chk_zero("mid_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("post_reset_valids", {508'd0, c1v, s1v, c2v, s2v}, '0);
      end
      step(1, 43, 0, 0, 0, '0, '0);
      step(0, 0, 1, 22, 0, '0, '0);

`ifdef CACHE_DATA_PARITY_EN
      // T6: corrupt a stored bit, expect par_err; rewrite and expect clean
      step(0, 0, 0, 0, 60, '1, pat(40));
      @(negedge clk); #1;
      idle();
      dut_l1.r_mem[60][3] = ~dut_l1.r_mem[60][3];
      dut_l2.r_mem[60][3] = ~dut_l2.r_mem[60][3];
      mdl[60][3] = ~mdl[60][3];
      exp_par = 1'b1;
      step(1, 60, 0, 0, 0, '0, '0);
      exp_par = 1'b0;
      step(0, 0, 0, 0, 60, '1, pat(41));
      step(1, 60, 0, 0, 0, '0, '0);
`endif

      @(negedge clk); #1;
      idle();
      repeat (4) @(negedge clk);
      #1;
      for (int ch = 0; ch < 4; ch++) chk("queue_drained", 512'(q[ch].size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
